vmop_wb: RTL
============

# vmop_wb

Write-back stage directly downstream of the vector mask-logical pipeline. The pipeline has no backpressure, so this block buffers its result words in a FIFO. It applies vl-based tail handling to each word and presents the words to the mask register-file write port with a valid/ready handshake. It returns an issue credit (`iss_ready`) to the upstream sequencer so that results in flight are never dropped, and pulses `op_done` when every word of the current operation has been written back.

## Interface
- `DATA_WIDTH`, 64: mask word width; equals the mask pipeline data width.
- `ADDR_WIDTH`, 32: mask word address width.
- `VL_WIDTH`, 16: width of the vl field, counted in mask bits.
- `FIFO_DEPTH`, 8: number of buffered result words; power of two, ≥ 8.

Ports:
- `clk`  in  1  clock, all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_start`  in  1  one-cycle pulse: latch `cfg_vl` and begin a new operation.
- `cfg_vl`  in  VL_WIDTH  number of active mask bits in the operation.
- `iss_valid`  in  1  copy of the mask pipeline's input valid; used for credit accounting.
- `iss_ready`  out  1  upstream may issue this cycle.
- `res_valid`  in  1  result word valid from the mask pipeline.
- `res_addr`  in  ADDR_WIDTH  word address of the result.
- `res_vec`  in  DATA_WIDTH  result word.
- `wb_valid`  out  1  write-back request.
- `wb_addr`  out  ADDR_WIDTH  write-back word address.
- `wb_data`  out  DATA_WIDTH  write-back data.
- `wb_ready`  in  1  register file accepts the write.
- `op_done`  out  1  one-cycle completion pulse.
- `ovf_err`  out  1  sticky overflow flag; cleared only by reset.

## Operation
- **Credit accounting.**
  - `inflight` counter: +1 on `iss_valid`, −1 on `res_valid`; both in the same cycle leaves it unchanged.
  - `iss_ready = (fifo_count + inflight) < FIFO_DEPTH`. The upstream issues only when `iss_ready` is high.
- **Tail handling.** Bit b of a word at address a has element index `a*DATA_WIDTH + b`.
  - Index < `vl_q`: the bit passes unchanged.
  - Index ≥ `vl_q`: handled as defined under Configuration.
  - The mask is computed combinationally at push time; the FIFO stores masked data.
- **Push.** Every `res_valid` pushes {`res_addr`, masked `res_vec`}.
  - Push while full with no pop in the same cycle: the word is dropped and `ovf_err` is set.
  - Push and pop in the same cycle while full: both succeed.
- **Pop.** The FIFO is show-ahead.
  - `wb_valid` = not empty; `wb_addr`/`wb_data` = head entry.
  - Pop on `wb_valid && wb_ready`.
  - While `wb_valid` is high and `wb_ready` is low, `wb_addr`/`wb_data` hold stable.
- **Completion tracking.**
  - On `cfg_start`: `vl_q <= cfg_vl`, `expected <= ceil(cfg_vl/DATA_WIDTH)`, `wb_cnt <= 0`, `active <= 1`.
  - Each handshake while `active` increments `wb_cnt`.
  - When the handshake brings `wb_cnt` to `expected`: `active <= 0`, and `op_done` pulses in the next cycle.
  - `cfg_vl = 0`: `op_done` pulses in the cycle after `cfg_start`.
  - `cfg_start` while `active`: restart. Counters reload, FIFO contents are kept, and any handshake in the same cycle is not counted.
  - Handshakes while not `active` are still performed but not counted.
- **Reset values** (asynchronous):
  - `wb_valid`=0, `wb_addr`=0, `wb_data`=0, `op_done`=0, `ovf_err`=0.
  - `iss_ready`=1; FIFO empty, `inflight`=0, `active`=0, `vl_q`=0.
  - Reset mid-operation discards all buffered and in-flight words.

## Timing
- `res_valid` at cycle t into an empty FIFO → `wb_valid` high at t+1.
- `iss_ready` is registered; it reflects counters updated at the previous edge.
- Pipeline latency is 6 cycles (`VMOP_LATENCY`); credits cover all of it.
- Throughput is one word per cycle when `wb_ready` is held high.
- `op_done` fires 1 cycle after the final handshake.

## Configuration
- `VMOP_WB_TAIL_ONES_EN` defined: bits with element index ≥ `vl_q` are forced to 1 (tail-agnostic all-ones).
- Not defined: tail bits pass unchanged and the index comparator is not built.

## Structure
- Package `vmop_pkg`:
  - `VMOP_LATENCY` = 6
  - mask opSel encoding constants (3-bit, AND…XNOR)
  - typedef `vmop_wb_entry_t` {addr, data}
- Sub-module `vmop_wb_fifo`: parameterised show-ahead synchronous FIFO with count, full and empty outputs, asynchronous active-low reset.

## Test plan
- **Basic write-back:** reset, `cfg_vl`=128, two results at addr 0/1 with `wb_ready`=1 → two writes with data unchanged; `op_done` 1 cycle after the 2nd handshake.
- **Tail masking:** `cfg_vl`=70, `res_vec`=0 at addr 1 → `wb_data`=0xFFFF_FFFF_FFFF_FFC0 with the macro, 0 without.
- **Backpressure and credit:** `wb_ready`=0, issue until `iss_ready` drops → exactly 8 words accepted, no `ovf_err`; release `wb_ready` → words drain in order.
- **Overflow:** force `res_valid` for 9 cycles with `wb_ready`=0 → `ovf_err`=1 and stays set; the 9th word is not written.
- **Zero vl and restart:** `cfg_vl`=0 → `op_done` next cycle. Restart `cfg_vl`=64 mid-op → a single further handshake yields `op_done`.
- **Reset mid-operation:** deassert `rst_n` with 4 words buffered → `wb_valid`=0 and `iss_ready`=1 immediately, with no later writes.

Source files
------------

// File: rtl/vmop_pkg.sv
// Shared constants and types for the vector mask-logical pipeline and its write-back stage.
package vmop_pkg;

    localparam int VMOP_LATENCY = 6;
    localparam int VMOP_DATA_W  = 64;
    localparam int VMOP_ADDR_W  = 32;

    // Mask-logical opSel encodings
    localparam logic [2:0] VMOP_AND  = 3'd0;
    localparam logic [2:0] VMOP_NAND = 3'd1;
    localparam logic [2:0] VMOP_ANDN = 3'd2;
    localparam logic [2:0] VMOP_XOR  = 3'd3;
    localparam logic [2:0] VMOP_OR   = 3'd4;
    localparam logic [2:0] VMOP_NOR  = 3'd5;
    localparam logic [2:0] VMOP_ORN  = 3'd6;
    localparam logic [2:0] VMOP_XNOR = 3'd7;

    typedef struct packed {
        logic [VMOP_ADDR_W-1:0] addr;
        logic [VMOP_DATA_W-1:0] data;
    } vmop_wb_entry_t;

endpackage

// File: rtl/vmop_wb_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on rdata whenever not empty.
module vmop_wb_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr, rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign rdata = mem[rd_ptr];

    // Storage is cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vmop_wb.sv
// Mask-pipeline write-back stage: credit-based buffering, tail handling and completion tracking.
// Optional feature: VMOP_WB_TAIL_ONES_EN forces tail bits (index >= vl) to 1.
module vmop_wb
    import vmop_pkg::*;
#(
    parameter int DATA_WIDTH = VMOP_DATA_W,
    parameter int ADDR_WIDTH = VMOP_ADDR_W,
    parameter int VL_WIDTH   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [VL_WIDTH-1:0]   cfg_vl,
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic                  res_valid,
    input  logic [ADDR_WIDTH-1:0] res_addr,
    input  logic [DATA_WIDTH-1:0] res_vec,
    output logic                  wb_valid,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  wb_ready,
    output logic                  op_done,
    output logic                  ovf_err
);
    localparam int LOG_DW = $clog2(DATA_WIDTH);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int EW     = VL_WIDTH - LOG_DW + 1;

    logic [DATA_WIDTH-1:0]            push_data;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;
    logic [CW-1:0]                    fifo_count, count_nxt;
    logic                             fifo_full, fifo_empty;
    logic                             hs, push_ok;

    assign hs      = wb_valid && wb_ready;
    assign push_ok = res_valid && (!fifo_full || hs);

`ifdef VMOP_WB_TAIL_ONES_EN
    localparam int XW = ((ADDR_WIDTH + LOG_DW) > VL_WIDTH ? ADDR_WIDTH + LOG_DW : VL_WIDTH) + 1;

    logic [VL_WIDTH-1:0]   vl_q;
    logic [XW-1:0]         base, vl_x, rem;
    logic [DATA_WIDTH-1:0] tail;

    // Word a covers indices [a*DW, a*DW+DW); rem is how many of them are active.
    always_comb begin
        base = XW'({res_addr, {LOG_DW{1'b0}}});
        vl_x = XW'(vl_q);
        rem  = vl_x - base;
        tail = '0;
        if (vl_x <= base)
            tail = '1;
        else if (rem < XW'(DATA_WIDTH))
            tail = {DATA_WIDTH{1'b1}} << rem[LOG_DW-1:0];
        push_data = res_vec | tail;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         vl_q <= '0;
        else if (cfg_start) vl_q <= cfg_vl;
    end
`else
    assign push_data = res_vec;
`endif

    vmop_wb_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .wdata ({res_addr, push_data}),
        .pop   (hs),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wb_valid           = !fifo_empty;
    assign {wb_addr, wb_data} = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             ovf_err <= 1'b0;
        else if (res_valid && fifo_full && !hs) ovf_err <= 1'b1;
    end

    // Credits: buffered words plus words still inside the pipeline.
    logic [CW:0]   inflight, inflight_nxt;
    logic [CW+1:0] occ_nxt;

    always_comb begin
        inflight_nxt = inflight;
        if (iss_valid && !res_valid && inflight != '1)
            inflight_nxt = inflight + 1'b1;
        else if (!iss_valid && res_valid && inflight != '0)
            inflight_nxt = inflight - 1'b1;
        count_nxt = fifo_count;
        if (push_ok && !hs)      count_nxt = fifo_count + 1'b1;
        else if (!push_ok && hs) count_nxt = fifo_count - 1'b1;
        occ_nxt = (CW+2)'(count_nxt) + (CW+2)'(inflight_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight  <= '0;
            iss_ready <= 1'b1;
        end else begin
            inflight  <= inflight_nxt;
            iss_ready <= (occ_nxt < (CW+2)'(FIFO_DEPTH));
        end
    end

    // Completion tracking
    logic [EW-1:0] expected, wb_cnt, exp_start, cnt_inc;
    logic          active;

    assign exp_start = EW'(cfg_vl[VL_WIDTH-1:LOG_DW]) + EW'(|cfg_vl[LOG_DW-1:0]);
    assign cnt_inc   = wb_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected <= '0;
            wb_cnt   <= '0;
            active   <= 1'b0;
            op_done  <= 1'b0;
        end else begin
            op_done <= 1'b0;
            if (cfg_start) begin
                expected <= exp_start;
                wb_cnt   <= '0;
                active   <= (exp_start != '0);
                op_done  <= (exp_start == '0);
            end else if (hs && active) begin
                wb_cnt <= cnt_inc;
                if (cnt_inc == expected) begin
                    active  <= 1'b0;
                    op_done <= 1'b1;
                end
            end
        end
    end

endmodule
